// File: rtl/iscas_bist_pkg.sv
// Shared types and constants for the s526n-class BIST driver.
// The state enum, default LFSR/MISR constants and pin-interface widths live here.
package iscas_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } bist_state_e;

  localparam logic [15:0] DEF_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

  localparam int STIM_W = 3;
  localparam int RESP_W = 6;
  localparam int SIG_W  = 16;

endpackage

// File: rtl/bist_galois_reg.sv
// Right-shifting Galois register with a synchronous load and an XOR input.
// It serves as the stimulus LFSR (din = 0) or as the response MISR.
module bist_galois_reg #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'hB400,
  parameter logic [WIDTH-1:0] INIT  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] step_s;

  // One Galois step of the current value
  always_comb begin
    step_s = {1'b0, q_r[WIDTH-1:1]} ^ (q_r[0] ? POLY : {WIDTH{1'b0}});
  end

  // Register: load has priority over stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= INIT;
    end else if (load) begin
      q_r <= load_val;
    end else if (en) begin
      q_r <= step_s ^ din;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/iscas_bist_driver.sv
// BIST stimulus/response driver for an s526n-class core: LFSR stimulus, MISR signature.
// Optional `BIST_SEED_LOAD_EN adds SEED_IN, a run-time LFSR start value.
module iscas_bist_driver
  import iscas_bist_pkg::*;
#(
  parameter logic [15:0] SEED       = DEF_SEED,
  parameter logic [15:0] POLY       = DEF_POLY,
  parameter int          RUN_CYC    = 1024,
  parameter int          FLUSH_CYC  = 4,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              START,
`ifdef BIST_SEED_LOAD_EN
  input  logic [15:0]       SEED_IN,
`endif
  input  logic [RESP_W-1:0] DUT_RESP,
  output logic [STIM_W-1:0] DUT_STIM,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [SIG_W-1:0]  SIG
);

  localparam int CNT_MAX = (RUN_CYC > FLUSH_CYC) ? RUN_CYC : FLUSH_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYC - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYC - 1);

  bist_state_e       state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [SIG_W-1:0]  lfsr_q, misr_q, seed_start_s;
  logic              lfsr_en_s, lfsr_load_s, misr_en_s, misr_load_s;
  logic [STIM_W-1:0] stim_s;
  logic              busy_s, done_s;

`ifdef BIST_SEED_LOAD_EN
  assign seed_start_s = (SEED_IN == 16'h0000) ? SEED : SEED_IN;
`else
  assign seed_start_s = SEED;
`endif

  // State and cycle counter
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state, counter and decoded controls/outputs
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    lfsr_en_s   = 1'b0;
    lfsr_load_s = 1'b0;
    misr_en_s   = 1'b0;
    misr_load_s = 1'b0;
    stim_s      = 3'b000;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        done_s = (state_r == S_DONE);
        if (START) begin
          state_s     = S_FLUSH;
          cnt_s       = {CNT_W{1'b0}};
          lfsr_load_s = 1'b1;
          misr_load_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      S_FLUSH: begin
        stim_s = 3'b001;
        busy_s = 1'b1;
        if (cnt_r == FLUSH_LAST) begin
          state_s = S_RUN;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_RUN: begin
        stim_s    = lfsr_q[STIM_W-1:0];
        busy_s    = 1'b1;
        // Core outputs lag stimulus by one cycle, so cycle 0 has nothing to capture
        misr_en_s = (cnt_r != {CNT_W{1'b0}});
        // A zero LFSR can only come from an upset; reseed rather than stall
        if (lfsr_q == 16'h0000) begin
          lfsr_load_s = 1'b1;
        end else begin
          lfsr_en_s = 1'b1;
        end
        if (cnt_r == RUN_LAST) begin
          state_s = S_DRAIN;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        busy_s    = 1'b1;
        misr_en_s = 1'b1;
        state_s   = S_DONE;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  bist_galois_reg #(.WIDTH(SIG_W), .POLY(POLY), .INIT(SEED)) u_lfsr (
    .clk      (CK),
    .rst_n    (RN),
    .en       (lfsr_en_s),
    .load     (lfsr_load_s),
    .load_val (seed_start_s),
    .din      ({SIG_W{1'b0}}),
    .q        (lfsr_q)
  );

  bist_galois_reg #(.WIDTH(SIG_W), .POLY(POLY), .INIT(16'h0000)) u_misr (
    .clk      (CK),
    .rst_n    (RN),
    .en       (misr_en_s),
    .load     (misr_load_s),
    .load_val ({SIG_W{1'b0}}),
    .din      ({{(SIG_W-RESP_W){1'b0}}, DUT_RESP}),
    .q        (misr_q)
  );

  assign DUT_STIM = stim_s;
  assign BUSY     = busy_s;
  assign DONE     = done_s;
  assign PASS     = done_s && (misr_q == GOLDEN_SIG);
  assign SIG      = misr_q;

endmodule

// File: doc/iscas_bist_driver.md
Name: iscas_bist_driver

Overview:
- Stimulus source and response sink for the s526n-class benchmark core. It sits on the opposite side of the core's 3-in/6-out pin interface.
- Drives the core's G0/G1/G2 inputs from an LFSR and compacts its six outputs (G147,G148,G198,G199,G213,G214) into a MISR signature.
- Run sequencing: flush the core with G0=1, run a fixed number of pseudo-random cycles, drain, then report the signature and pass/fail against a golden value.

Parameters:
- SEED, 16'hACE1, LFSR start value; must be nonzero.
- POLY, 16'hB400, Galois tap mask shared by the LFSR and the MISR.
- RUN_CYC, 1024, number of stimulus cycles (≥2).
- FLUSH_CYC, 4, number of cycles G0 is held high before the run (≥1).
- GOLDEN_SIG, 16'h0000, expected MISR signature.

Ports:
- CK  in  1  clock, rising edge.
- RN  in  1  asynchronous active-low reset.
- START  in  1  run request, level-sampled.
- DUT_RESP  in  6  core outputs {G214,G213,G199,G198,G148,G147}.
- DUT_STIM  out  3  core inputs {G2,G1,G0}.
- BUSY  out  1  high in FLUSH/RUN/DRAIN.
- DONE  out  1  high in DONE state.
- PASS  out  1  SIG==GOLDEN_SIG; valid only while DONE=1, 0 otherwise.
- SIG  out  16  current MISR value.

Behaviour:
- One clock, CK. Reset is asynchronous, active-low on RN. All state registered.
- RN=0 forces: state=IDLE, lfsr=SEED, misr=0, cnt=0, DUT_STIM=0, BUSY=0, DONE=0, PASS=0, SIG=0. This applies mid-run too; the run is discarded.
- Galois step: nxt = (r>>1) ^ (r[0] ? POLY : 0). MISR step: nxt = galois(misr) ^ {10'b0, DUT_RESP}.
- Counter cnt has width $clog2(RUN_CYC+1).
- IDLE:
  - DUT_STIM=0.
  - START=1 → FLUSH, with cnt=0, lfsr=SEED, misr=0.
- FLUSH:
  - DUT_STIM=3'b001 (G0=1 synchronously clears the core).
  - cnt increments each cycle.
  - After FLUSH_CYC cycles → RUN, with cnt=0.
- RUN:
  - DUT_STIM=lfsr[2:0] combinationally from the lfsr register; lfsr steps every cycle.
  - The core's outputs are registered, so the response to stimulus k appears in cycle k+1. The MISR therefore updates in RUN cycles 1..RUN_CYC-1 (not cycle 0), and once more in DRAIN: exactly RUN_CYC captures.
  - After RUN_CYC cycles → DRAIN.
- DRAIN (1 cycle):
  - DUT_STIM=0; the MISR captures the final response.
  - Next state DONE.
- DONE:
  - DONE=1, PASS=(misr==GOLDEN_SIG); SIG frozen.
  - START=1 → FLUSH, re-initialising as from IDLE.
  - START=0 → stay in DONE.
- START is ignored while BUSY=1. There is no abort; only RN stops a run.
- SIG tracks misr in every state.

Optional Feature:
- Macro BIST_SEED_LOAD_EN.
- Defined: adds port SEED_IN in 16, sampled on the IDLE/DONE→FLUSH transition as the LFSR start value. SEED_IN=0 is replaced by SEED, so the LFSR never locks up. Reset value of lfsr remains SEED.
- Undefined: no port; the start value is always SEED.

Decomposition:
- Package iscas_bist_pkg holds:
  - state enum {IDLE, FLUSH, RUN, DRAIN, DONE};
  - constant DEF_POLY=16'hB400, DEF_SEED=16'hACE1;
  - widths STIM_W=3, RESP_W=6, SIG_W=16.
- Sub-module bist_galois_reg (width, poly, init; en, din; q), instantiated twice:
  - LFSR with din=0;
  - MISR with din=DUT_RESP zero-extended.

Test Plan:
1. Reset, then START=1 for one cycle, FLUSH_CYC=4 → BUSY rises next edge; DUT_STIM=3'b001 for 4 cycles; then DUT_STIM=3'b001 (seed 0xACE1) in RUN cycle 0 and 3'b000 (lfsr 0xE270) in cycle 1.
2. RUN_CYC=8, DUT_RESP tied 0 → 8 MISR captures starting from misr=0; SIG=0 at DONE; PASS=1 with GOLDEN_SIG=0. With GOLDEN_SIG=16'h1234: PASS=0, DONE=1 held while START=0.
3. Bench reference model of the real s526n core, RUN_CYC=1024 → SIG equals the model-computed signature. Flipping one DUT_RESP bit in any single cycle gives SIG≠model and PASS=0.
4. RN pulsed low in RUN cycle 500 → all outputs 0 within the same cycle. START after release gives a full run whose SIG matches test 3.
5. START held high throughout → no restart while BUSY. DONE lasts one cycle, then FLUSH re-enters with the same SEED and the identical SIG is reproduced.
6. BIST_SEED_LOAD_EN with SEED_IN=0 → stimulus identical to the SEED run. SEED_IN=16'h0001 → RUN cycle 0 stim 3'b001, cycle 1 stim 3'b000 (lfsr 0xB400).
